// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory word port between the
//               instruction cache (read-only) and data cache (read/write),
//               with a per-transaction response timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  I_REQ,
    input  logic [ADDR_WIDTH-1:0] I_ADDR,
    output logic [DATA_WIDTH-1:0] I_RDATA,
    output logic                  I_RVALID,
    output logic                  I_ERR,

    input  logic                  D_RD,
    input  logic                  D_WR,
    input  logic [ADDR_WIDTH-1:0] D_ADDR,
    input  logic [DATA_WIDTH-1:0] D_WDATA,
    output logic [DATA_WIDTH-1:0] D_RDATA,
    output logic                  D_RVALID,
    output logic                  D_WDONE,
    output logic                  D_ERR,

    output logic                  MEM_READ_REQ,
    output logic                  MEM_WRITE_REQ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic                  MEM_BUSYWAIT,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_READDATA_VALID,
    input  logic                  MEM_WRITE_DONE,

    output logic                  ARB_BUSY
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    localparam logic [TMO_WIDTH-1:0] c_TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state,     w_state_nx;
    logic                  r_owner_d,   w_owner_d_nx;
    logic                  r_op_wr,     w_op_wr_nx;
    logic                  r_last_d,    w_last_d_nx;
    logic [TMO_WIDTH-1:0]  r_tmo,       w_tmo_nx;
    logic                  r_mem_rd,    w_mem_rd_nx;
    logic                  r_mem_wr,    w_mem_wr_nx;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nx;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nx;
    logic [DATA_WIDTH-1:0] r_i_rdata,   w_i_rdata_nx;
    logic [DATA_WIDTH-1:0] r_d_rdata,   w_d_rdata_nx;
    logic                  r_i_rvalid,  w_i_rvalid_nx;
    logic                  r_i_err,     w_i_err_nx;
    logic                  r_d_rvalid,  w_d_rvalid_nx;
    logic                  r_d_wdone,   w_d_wdone_nx;
    logic                  r_d_err,     w_d_err_nx;
    logic                  r_busy,      w_busy_nx;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_d;
    logic w_blocked;
    logic w_resp_hit;

    assign w_i_pend   = I_REQ;
    assign w_d_pend   = D_RD | D_WR;
    assign w_grant_d  = w_d_pend & (~w_i_pend | ~r_last_d);
    // The requester still holds its request while it sees its completion
    // pulse; granting in that cycle would start a phantom repeat transaction.
    assign w_blocked  = r_i_rvalid | r_i_err | r_d_rvalid | r_d_wdone | r_d_err;
    assign w_resp_hit = r_op_wr ? MEM_WRITE_DONE : MEM_READDATA_VALID;

    always_comb begin
        w_state_nx     = r_state;
        w_owner_d_nx   = r_owner_d;
        w_op_wr_nx     = r_op_wr;
        w_last_d_nx    = r_last_d;
        w_tmo_nx       = r_tmo;
        w_mem_rd_nx    = r_mem_rd;
        w_mem_wr_nx    = r_mem_wr;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_i_rdata_nx   = r_i_rdata;
        w_d_rdata_nx   = r_d_rdata;
        w_i_rvalid_nx  = 1'b0;
        w_i_err_nx     = 1'b0;
        w_d_rvalid_nx  = 1'b0;
        w_d_wdone_nx   = 1'b0;
        w_d_err_nx     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (!w_blocked && (w_i_pend || w_d_pend)) begin
                    w_owner_d_nx  = w_grant_d;
                    w_op_wr_nx    = w_grant_d & D_WR;
                    w_last_d_nx   = w_grant_d;
                    w_mem_addr_nx = w_grant_d ? D_ADDR : I_ADDR;
                    if (w_grant_d) begin
                        w_mem_wdata_nx = D_WDATA;
                    end
                    w_mem_rd_nx   = ~(w_grant_d & D_WR);
                    w_mem_wr_nx   = w_grant_d & D_WR;
                    w_state_nx    = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (!MEM_BUSYWAIT) begin
                    w_mem_rd_nx = 1'b0;
                    w_mem_wr_nx = 1'b0;
                    w_tmo_nx    = '0;
                    w_state_nx  = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                if (w_resp_hit) begin
                    w_state_nx = c_ST_IDLE;
                    if (r_op_wr) begin
                        w_d_wdone_nx = 1'b1;
                    end else if (r_owner_d) begin
                        w_d_rvalid_nx = 1'b1;
                        w_d_rdata_nx  = MEM_READDATA;
                    end else begin
                        w_i_rvalid_nx = 1'b1;
                        w_i_rdata_nx  = MEM_READDATA;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nx = c_ST_IDLE;
                    w_d_err_nx = r_owner_d;
                    w_i_err_nx = ~r_owner_d;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                end
            end
            default: begin
                w_state_nx  = c_ST_IDLE;
                w_mem_rd_nx = 1'b0;
                w_mem_wr_nx = 1'b0;
            end
        endcase

        w_busy_nx = (w_state_nx != c_ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_owner_d   <= 1'b0;
            r_op_wr     <= 1'b0;
            r_last_d    <= 1'b1;
            r_tmo       <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_rvalid  <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_wdone   <= 1'b0;
            r_d_err     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_owner_d   <= w_owner_d_nx;
            r_op_wr     <= w_op_wr_nx;
            r_last_d    <= w_last_d_nx;
            r_tmo       <= w_tmo_nx;
            r_mem_rd    <= w_mem_rd_nx;
            r_mem_wr    <= w_mem_wr_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
            r_i_rdata   <= w_i_rdata_nx;
            r_d_rdata   <= w_d_rdata_nx;
            r_i_rvalid  <= w_i_rvalid_nx;
            r_i_err     <= w_i_err_nx;
            r_d_rvalid  <= w_d_rvalid_nx;
            r_d_wdone   <= w_d_wdone_nx;
            r_d_err     <= w_d_err_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign I_RDATA       = r_i_rdata;
    assign I_RVALID      = r_i_rvalid;
    assign I_ERR         = r_i_err;
    assign D_RDATA       = r_d_rdata;
    assign D_RVALID      = r_d_rvalid;
    assign D_WDONE       = r_d_wdone;
    assign D_ERR         = r_d_err;
    assign MEM_READ_REQ  = r_mem_rd;
    assign MEM_WRITE_REQ = r_mem_wr;
    assign MEM_ADDRESS   = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;
    assign ARB_BUSY      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_port_arbiter
// Description : Randomized self-checking bench for mem_port_arbiter against a
//               transaction-level model of arbitration, latency and routing.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    localparam int c_AW  = 32;
    localparam int c_DW  = 32;
    localparam int c_TMO = 8;

    logic            clk;
    logic            reset;
    logic            I_REQ;
    logic [c_AW-1:0] I_ADDR;
    logic [c_DW-1:0] I_RDATA;
    logic            I_RVALID, I_ERR;
    logic            D_RD, D_WR;
    logic [c_AW-1:0] D_ADDR;
    logic [c_DW-1:0] D_WDATA, D_RDATA;
    logic            D_RVALID, D_WDONE, D_ERR;
    logic            MEM_READ_REQ, MEM_WRITE_REQ;
    logic [c_AW-1:0] MEM_ADDRESS;
    logic [c_DW-1:0] MEM_WRITEDATA;
    logic            MEM_BUSYWAIT;
    logic [c_DW-1:0] MEM_READDATA;
    logic            MEM_READDATA_VALID, MEM_WRITE_DONE;
    logic            ARB_BUSY;

    mem_port_arbiter #(
        .ADDR_WIDTH     (c_AW),
        .DATA_WIDTH     (c_DW),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .I_REQ              (I_REQ),
        .I_ADDR             (I_ADDR),
        .I_RDATA            (I_RDATA),
        .I_RVALID           (I_RVALID),
        .I_ERR              (I_ERR),
        .D_RD               (D_RD),
        .D_WR               (D_WR),
        .D_ADDR             (D_ADDR),
        .D_WDATA            (D_WDATA),
        .D_RDATA            (D_RDATA),
        .D_RVALID           (D_RVALID),
        .D_WDONE            (D_WDONE),
        .D_ERR              (D_ERR),
        .MEM_READ_REQ       (MEM_READ_REQ),
        .MEM_WRITE_REQ      (MEM_WRITE_REQ),
        .MEM_ADDRESS        (MEM_ADDRESS),
        .MEM_WRITEDATA      (MEM_WRITEDATA),
        .MEM_BUSYWAIT       (MEM_BUSYWAIT),
        .MEM_READDATA       (MEM_READDATA),
        .MEM_READDATA_VALID (MEM_READDATA_VALID),
        .MEM_WRITE_DONE     (MEM_WRITE_DONE),
        .ARB_BUSY           (ARB_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: round-robin memory and last value delivered per port
    bit              m_last_d;
    logic [c_DW-1:0] m_i_rdata;
    logic [c_DW-1:0] m_d_rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse order: I_RVALID, I_ERR, D_RVALID, D_WDONE, D_ERR
    task automatic check_pulses(input string tag, input logic [4:0] exp);
        check_eq({tag, "_pulse"}, {I_RVALID, I_ERR, D_RVALID, D_WDONE, D_ERR}, exp);
        check_eq({tag, "_irdata"}, I_RDATA, m_i_rdata);
        check_eq({tag, "_drdata"}, D_RDATA, m_d_rdata);
    endtask

    task automatic drop_owner(input bit own_d);
        if (own_d) begin D_RD = 1'b0; D_WR = 1'b0; end
        else I_REQ = 1'b0;
    endtask

    // Called #1 after an edge; the grant is expected on the next edge.
    task automatic do_txn(input bit own_d, input bit wr, input logic [c_AW-1:0] addr,
                          input logic [c_DW-1:0] wdata);
        int              busy;
        int              lat;
        int              n;
        bit              tmo;
        bit              hold_extra;
        logic [c_DW-1:0] rd;
        logic [4:0]      exp;

        busy       = $urandom_range(0, 3);
        tmo        = ($urandom_range(0, 5) == 0);
        lat        = $urandom_range(1, 3);
        hold_extra = $urandom_range(0, 1);
        rd         = $urandom;
        n          = tmo ? c_TMO : lat;

        step();
        check_eq("grant_req", {MEM_READ_REQ, MEM_WRITE_REQ}, {~wr, wr});
        check_eq("grant_addr", MEM_ADDRESS, addr);
        if (wr) check_eq("grant_wdata", MEM_WRITEDATA, wdata);
        check_eq("grant_busy", ARB_BUSY, 1'b1);
        m_last_d = own_d;
        if ($urandom_range(0, 3) == 0) drop_owner(own_d);

        for (int k = 0; k < busy; k++) begin
            MEM_BUSYWAIT = 1'b1;
            MEM_READDATA = $urandom;
            MEM_READDATA_VALID = ($urandom_range(0, 2) == 0);
            MEM_WRITE_DONE = ($urandom_range(0, 2) == 0);
            step();
            MEM_READDATA_VALID = 1'b0;
            MEM_WRITE_DONE = 1'b0;
            check_eq("issue_hold", {MEM_READ_REQ, MEM_WRITE_REQ}, {~wr, wr});
            check_eq("issue_addr", MEM_ADDRESS, addr);
            check_pulses("issue", 5'b0);
        end
        MEM_BUSYWAIT = 1'b0;
        step();
        check_eq("accept_req", {MEM_READ_REQ, MEM_WRITE_REQ}, 2'b00);

        for (int k = 1; k <= n; k++) begin
            if (!tmo && k == lat) begin
                MEM_READDATA = rd;
                if (wr) MEM_WRITE_DONE = 1'b1;
                else MEM_READDATA_VALID = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
                MEM_READDATA = $urandom;
                if (wr) MEM_READDATA_VALID = 1'b1;
                else MEM_WRITE_DONE = 1'b1;
            end
            step();
            MEM_READDATA_VALID = 1'b0;
            MEM_WRITE_DONE = 1'b0;
            if (k < n) begin
                check_pulses("resp_wait", 5'b0);
                check_eq("resp_busy", ARB_BUSY, 1'b1);
            end
        end

        exp = 5'b0;
        if (tmo) exp = own_d ? 5'b00001 : 5'b01000;
        else if (wr) exp = 5'b00010;
        else if (own_d) begin exp = 5'b00100; m_d_rdata = rd; end
        else begin exp = 5'b10000; m_i_rdata = rd; end
        check_pulses(tmo ? "timeout" : "done", exp);
        check_eq("done_busy", ARB_BUSY, 1'b0);

        if ($urandom_range(0, 1) == 1) begin
            MEM_READDATA = $urandom;
            if (wr) MEM_WRITE_DONE = 1'b1;
            else MEM_READDATA_VALID = 1'b1;
        end
        if (!hold_extra) drop_owner(own_d);
        step();
        MEM_READDATA_VALID = 1'b0;
        MEM_WRITE_DONE = 1'b0;
        if (hold_extra) drop_owner(own_d);
        check_pulses("late", 5'b0);
        check_eq("gap_req", {MEM_READ_REQ, MEM_WRITE_REQ, ARB_BUSY}, 3'b000);
    endtask

    initial begin
        int              mode;
        int              sel;
        logic [c_AW-1:0] ia;
        logic [c_AW-1:0] da;
        logic [c_DW-1:0] dw;

        reset = 1'b0;
        I_REQ = 1'b0; I_ADDR = '0;
        D_RD = 1'b0; D_WR = 1'b0; D_ADDR = '0; D_WDATA = '0;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = '0;
        MEM_READDATA_VALID = 1'b0; MEM_WRITE_DONE = 1'b0;
        m_last_d = 1'b1; m_i_rdata = '0; m_d_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check_pulses("reset", 5'b0);
        check_eq("reset_ctl", {MEM_READ_REQ, MEM_WRITE_REQ, ARB_BUSY}, 3'b000);
        check_eq("reset_addr", MEM_ADDRESS, '0);
        check_eq("reset_wdata", MEM_WRITEDATA, '0);
        #3 reset = 1'b1;
        step();

        for (int ep = 0; ep < 60; ep++) begin
            mode = $urandom_range(0, 2);
            sel  = $urandom_range(0, 2);
            ia = $urandom; da = $urandom; dw = $urandom;
            if (ep == 0) begin mode = 0; ia = 32'h100; end
            I_ADDR = ia; D_ADDR = da; D_WDATA = dw;
            I_REQ = (mode != 1);
            D_RD  = (mode != 0) && (sel != 1);
            D_WR  = (mode != 0) && (sel != 0);
            if (mode == 0) do_txn(1'b0, 1'b0, ia, dw);
            else if (mode == 1) do_txn(1'b1, sel != 0, da, dw);
            else if (m_last_d) begin
                do_txn(1'b0, 1'b0, ia, dw);
                do_txn(1'b1, sel != 0, da, dw);
            end else begin
                do_txn(1'b1, sel != 0, da, dw);
                do_txn(1'b0, 1'b0, ia, dw);
            end
        end

        // Reset while a read sits in RESP: no pulse may ever appear for it
        I_ADDR = 32'h200; I_REQ = 1'b1; MEM_BUSYWAIT = 1'b0;
        step();
        I_REQ = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        m_last_d = 1'b1; m_i_rdata = '0; m_d_rdata = '0;
        check_pulses("midrst", 5'b0);
        check_eq("midrst_ctl", {MEM_READ_REQ, MEM_WRITE_REQ, ARB_BUSY}, 3'b000);
        check_eq("midrst_addr", MEM_ADDRESS, '0);
        @(posedge clk);
        #4 reset = 1'b1;
        step();
        MEM_READDATA = 32'hDEADBEEF; MEM_READDATA_VALID = 1'b1;
        step();
        MEM_READDATA_VALID = 1'b0;
        check_pulses("post_rst_stray", 5'b0);
        I_ADDR = 32'h300; D_ADDR = 32'h2C; D_WDATA = 32'h12345678;
        I_REQ = 1'b1; D_RD = 1'b1; D_WR = 1'b1;
        do_txn(1'b0, 1'b0, 32'h300, 32'h12345678);
        do_txn(1'b1, 1'b1, 32'h2C, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory word port between the instruction-cache controller (read-only) and the data-cache controller (read/write, write-back).
- Runs one word transaction at a time. Each transaction is arbitrated, issued to memory with a request/busywait handshake, and its response is routed back to the owning requester.
- Round-robin between requesters. A per-transaction timeout prevents a hung memory from deadlocking either cache.
- Sits between both cache controllers and the memory model / bus bridge.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- DATA_WIDTH, 32, word width on all ports.
- TIMEOUT_CYCLES, 64, max cycles in RESP before the transaction is aborted with an error. Minimum 2.
- TMO_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_REQ  in  1  icache read request; held with I_ADDR until I_RVALID or I_ERR.
- I_ADDR  in  ADDR_WIDTH  icache word address.
- I_RDATA  out  DATA_WIDTH  read data; valid with I_RVALID.
- I_RVALID  out  1  1-cycle pulse, read complete.
- I_ERR  out  1  1-cycle pulse, transaction timed out.
- D_RD  in  1  dcache read request; held until D_RVALID or D_ERR.
- D_WR  in  1  dcache write request; held until D_WDONE or D_ERR.
- D_ADDR  in  ADDR_WIDTH  dcache word address.
- D_WDATA  in  DATA_WIDTH  dcache write data.
- D_RDATA  out  DATA_WIDTH  read data; valid with D_RVALID.
- D_RVALID  out  1  1-cycle pulse, read complete.
- D_WDONE  out  1  1-cycle pulse, write complete.
- D_ERR  out  1  1-cycle pulse, timeout.
- MEM_READ_REQ  out  1  memory read request.
- MEM_WRITE_REQ  out  1  memory write request.
- MEM_ADDRESS  out  ADDR_WIDTH  registered address of the active transaction.
- MEM_WRITEDATA  out  DATA_WIDTH  registered write data.
- MEM_BUSYWAIT  in  1  high means memory is not accepting the request this cycle.
- MEM_READDATA  in  DATA_WIDTH  memory read data.
- MEM_READDATA_VALID  in  1  1-cycle pulse, read data valid.
- MEM_WRITE_DONE  in  1  1-cycle pulse, write committed.
- ARB_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; last_owner=D, so I wins the first tie.
  - All outputs 0, including the MEM_ADDRESS/MEM_WRITEDATA registers.
  - Timeout counter = 0.
  - A reset mid-transaction abandons it; no response pulse is produced.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Pending requests: I_REQ for I; D_RD|D_WR for D.
  - Only one pending: grant it. Both pending: grant the one that is not last_owner.
  - On the grant edge: latch owner, op (write if D_WR), address, wdata; update last_owner; go to ISSUE.
  - D_RD and D_WR both high: treated as a write.
- ISSUE:
  - MEM_READ_REQ or MEM_WRITE_REQ = 1 with latched address/data.
  - If MEM_BUSYWAIT=0 this cycle, the request is accepted: drop the request, clear the timeout counter, go to RESP.
  - Otherwise hold. No timeout applies in ISSUE.
- RESP:
  - Wait for MEM_READDATA_VALID (read) or MEM_WRITE_DONE (write).
  - On the matching pulse, next cycle:
    - I read: I_RVALID=1 and I_RDATA=MEM_READDATA.
    - D read: D_RVALID=1 and D_RDATA=MEM_READDATA.
    - D write: D_WDONE=1.
    - Then go to IDLE.
  - The non-matching pulse type is ignored.
  - Counter increments each RESP cycle. When it reaches TIMEOUT_CYCLES, pulse the owner's *_ERR next cycle and go to IDLE.
- Latency: with memory idle and responding 1 cycle after acceptance:
  - Req seen at edge 0; MEM_*_REQ high in cycle 1; response in cycle 2; requester pulse in cycle 3.
  - Minimum 1 IDLE cycle between consecutive transactions.
- *_RDATA holds its last value until the next response to that port.
- Stray MEM_READDATA_VALID or MEM_WRITE_DONE in IDLE or ISSUE (e.g. a late response after a timeout) is dropped.
- A requester that drops its request while owning the port: the transaction still completes, and the pulse is still emitted.
- Memory contract: the response arrives no earlier than the cycle after acceptance.

Test Plan:
- I_REQ=1, I_ADDR=0x100; memory accepts immediately and returns 0xDEADBEEF 1 cycle later -> MEM_READ_REQ high for 1 cycle with MEM_ADDRESS=0x100; I_RVALID pulses exactly 3 cycles after req with I_RDATA=0xDEADBEEF; D_* stay 0.
- I_REQ and D_RD both asserted from reset, re-asserted after each completion, 4 transactions -> grant order I,D,I,D; each response is routed only to its owner.
- D_WR=1, D_ADDR=0x2C, D_WDATA=0x12345678; MEM_BUSYWAIT=1 for 5 cycles -> MEM_WRITE_REQ held 6 cycles with stable address/data; D_WDONE pulses 1 cycle after MEM_WRITE_DONE.
- D_RD accepted, memory never responds, TIMEOUT_CYCLES=8 -> D_ERR pulses once, 8 RESP cycles later; ARB_BUSY drops. A late MEM_READDATA_VALID afterwards produces no pulse.
- Reset asserted while in RESP, then released -> all outputs 0 and no RVALID/ERR pulse; the next I_REQ wins arbitration.
- D_RD and D_WR both high -> MEM_WRITE_REQ issued; only D_WDONE pulses.
